// File: rtl/output_mem_sched_if.sv
// Port bundle for the output-SRAM accumulation scheduler: two row requesters,
// clear/scan control, the two SRAM ports and status.
interface output_mem_sched_if #(
  parameter int ADDR_W = 7,
  parameter int LANES  = 16,
  parameter int LANE_W = 32
);
  localparam int DATA_W = LANES * LANE_W;

  // Requester handshake: a row transfers in a cycle where valid && ready.
  // While valid && !ready the requester holds addr/data/first stable;
  // ready is combinational and never depends on a transfer completing.
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_first;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_first;

  logic              clear_start;
  logic              clear_done;
  logic              scan_req;
  logic              scan_grant;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  logic              busy;
  logic [1:0]        state_dbg;

  modport master (
    output req0_valid, req0_addr, req0_data, req0_first,
    output req1_valid, req1_addr, req1_data, req1_first,
    output clear_start, scan_req, mem_rd_data,
    input  req0_ready, req1_ready, clear_done, scan_grant,
    input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  busy, state_dbg
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_first,
    input  req1_valid, req1_addr, req1_data, req1_first,
    input  clear_start, scan_req, mem_rd_data,
    output req0_ready, req1_ready, clear_done, scan_grant,
    output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
    output busy, state_dbg
  );
endinterface

// File: rtl/output_mem_sched.sv
// Round-robin read-add-write scheduler for the output SRAM with write forwarding,
// counter-driven whole-memory clear and drain-then-handover to the scan path.
module output_mem_sched #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int LANES  = 16,
  parameter int LANE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  output_mem_sched_if.slave   bus
);
  localparam int DATA_W = LANES * LANE_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {RUN = 2'd0, CLEAR = 2'd1, DRAIN = 2'd2, SCAN = 2'd3} state_t;

  state_t            state, state_n;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
  logic              last_grant, last_grant_n;
  logic              clear_done_q, clear_done_n;

  logic              grant_any;
  logic              grant_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              g_first;
  logic [DATA_W-1:0] old_row;
  logic [DATA_W-1:0] sum_row;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      pend_valid   <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      clr_cnt      <= '0;
      last_grant   <= 1'b1;
      clear_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      pend_valid   <= grant_any;
      clr_cnt      <= clr_cnt_n;
      last_grant   <= last_grant_n;
      clear_done_q <= clear_done_n;
      if (grant_any) begin
        pend_addr <= g_addr;
        pend_data <= sum_row;
      end
    end
  end

  always_comb begin
    state_n      = state;
    clr_cnt_n    = clr_cnt;
    clear_done_n = 1'b0;
    last_grant_n = last_grant;
    grant_any    = 1'b0;
    grant_sel    = 1'b0;
    case (state)
      RUN: begin
        if (bus.clear_start) begin
          state_n = CLEAR;
        end else if (bus.scan_req) begin
          state_n = DRAIN;
        end else if (reset && (bus.req0_valid || bus.req1_valid)) begin
          grant_any    = 1'b1;
          // Contention goes to whoever did not win last; a lone requester always wins.
          grant_sel    = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
          last_grant_n = grant_sel;
        end
      end
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          clr_cnt_n    = '0;
          clear_done_n = 1'b1;
          state_n      = RUN;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      DRAIN:   state_n = SCAN;
      SCAN:    if (!bus.scan_req) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Forwarding covers the row written this very cycle, which the SRAM cannot return yet.
  always_comb begin
    g_addr  = grant_sel ? bus.req1_addr  : bus.req0_addr;
    g_data  = grant_sel ? bus.req1_data  : bus.req0_data;
    g_first = grant_sel ? bus.req1_first : bus.req0_first;
    if (g_first)                              old_row = '0;
    else if (pend_valid && pend_addr == g_addr) old_row = pend_data;
    else                                      old_row = bus.mem_rd_data;
    sum_row = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_row[i*LANE_W +: LANE_W] = old_row[i*LANE_W +: LANE_W] + g_data[i*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    if (reset) begin
      if (state == CLEAR) begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = clr_cnt;
      end else if (state != SCAN && pend_valid) begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_addr = pend_addr;
        bus.mem_wr_data = pend_data;
      end
    end
  end

  assign bus.req0_ready  = grant_any && !grant_sel;
  assign bus.req1_ready  = grant_any &&  grant_sel;
  assign bus.mem_rd_en   = grant_any && !g_first;
  assign bus.mem_rd_addr = grant_any ? g_addr : '0;
  assign bus.clear_done  = reset && clear_done_q;
  assign bus.scan_grant  = reset && (state == SCAN);
  assign bus.busy        = reset && ((state != RUN) || pend_valid);
  assign bus.state_dbg   = state;
endmodule
